// File: rtl/multiplier_pkg.sv
// Shared types and Booth recoding helper for the sequential multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package multiplier_pkg;

   // Controller state encoding; the fourth code is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Operation selected by one radix-2 Booth recoding step.
   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ADD = 2'd1,
      OP_SUB = 2'd2
   } booth_op_t;

   // Decode {Q[0], q_1}: 01 adds M, 10 subtracts M, 00/11 leave A unchanged.
   function automatic booth_op_t booth_decode(input logic [1:0] pair);
      booth_op_t op;
      case (pair)
         2'b01:   op = OP_ADD;
         2'b10:   op = OP_SUB;
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_ctrl.sv
// Booth multiplier sequencer: FSM plus step counter, drives load/step strobes.
// Latency: WIDTH cycles in RUN after an accepted start, then one DONE cycle.
// Backpressure: start is only honoured in IDLE or DONE; ignored while busy.
module booth_ctrl
   import multiplier_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done,
   output logic load,
   output logic step
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t          state;
   logic [CW-1:0]   count;

   // A new operand pair is accepted whenever we are not iterating.
   assign load = start && ((state == IDLE) || (state == DONE));
   // Every RUN cycle performs exactly one add/sub-and-shift.
   assign step = (state == RUN);

   // State, step counter and registered busy/done flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= RUN;
                  count <= CW'(WIDTH - 1);
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            RUN: begin
               if (count == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  count <= count - CW'(1);
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier for signed operands, one step per clock.
// Latency: WIDTH+1 cycles from the accepted start edge to the done pulse.
// Backpressure: start ignored while busy; product held until next accepted start.
module booth_seq_multiplier
   import multiplier_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   // A carries a guard bit so A - M cannot overflow when M is the most negative value.
   logic [WIDTH:0]    a;
   logic [WIDTH:0]    m;
   logic [WIDTH-1:0]  q;
   logic              q_1;
   logic [WIDTH:0]    s;
   logic              load;
   logic              step;

   booth_ctrl #(
      .WIDTH (WIDTH)
   ) u_ctrl (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .busy  (busy),
      .done  (done),
      .load  (load),
      .step  (step)
   );

   // Booth add/subtract on the partial product, (WIDTH+1)-bit wraparound.
   always_comb begin
      s = a;
      case (booth_decode({q[0], q_1}))
         OP_ADD:  s = a + m;
         OP_SUB:  s = a - m;
         default: s = a;
      endcase
   end

   // Operand capture on load, arithmetic right shift of {S,Q,q_1} on each step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a   <= '0;
         m   <= '0;
         q   <= '0;
         q_1 <= 1'b0;
      end else if (load) begin
         a   <= '0;
         m   <= {multiplicand[WIDTH-1], multiplicand};
         q   <= multiplier;
         q_1 <= 1'b0;
      end else if (step) begin
         {a, q, q_1} <= {s[WIDTH], s, q};
      end
   end

   // After WIDTH steps the guard bit equals A[WIDTH-1], so it is dropped here.
   assign product = {a[WIDTH-1:0], q};

endmodule
